// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between fetch and data ports; fixed MEM_LAT access.
// Latency: grant edge -> MEM_LAT busy cycles -> one ready cycle -> idle; requesters stall until their ready pulse.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_I = 2'd1;
    localparam logic [1:0] S_BUSY_D = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             last_gnt;   // 1 = data side won the most recent tie
    logic             pick_d;

    // On a tie the side that did not win the previous tie goes first.
    always_comb begin
        pick_d = d_req && (!i_req || !last_gnt);
    end

    assign i_stall = i_req & ~i_ready;
    assign d_stall = d_req & ~d_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            last_gnt  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        state     <= pick_d ? S_BUSY_D : S_BUSY_I;
                        mem_en    <= 1'b1;
                        mem_we    <= pick_d & d_we;
                        mem_addr  <= pick_d ? d_addr : i_addr;
                        mem_wdata <= pick_d ? d_wdata : '0;
                        cnt       <= CNT_INIT;
                        if (i_req && d_req) begin
                            last_gnt <= pick_d;
                        end
                    end
                end
                S_BUSY_I, S_BUSY_D: begin
                    if (cnt == '0) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= S_DONE;
                        if (state == S_BUSY_I) begin
                            i_ready <= 1'b1;
                            i_rdata <= mem_rdata;
                        end else begin
                            d_ready <= 1'b1;
                            // a write leaves the last read word visible
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random requesters checked against a timeline-based transaction model.
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_req, i_ready, i_stall, d_req, d_we, d_ready, d_stall;
    logic        mem_en, mem_we;
    logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        i_req1, i_ready1, i_stall1, d_req1, d_we1, d_ready1, d_stall1;
    logic        mem_en1, mem_we1;
    logic [15:0] i_addr1, i_rdata1, d_addr1, d_wdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req1), .i_addr(i_addr1), .i_ready(i_ready1), .i_rdata(i_rdata1), .i_stall(i_stall1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_ready(d_ready1), .d_rdata(d_rdata1), .d_stall(d_stall1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1)
    );

    // Memory: returns the true word only in the last enabled cycle, its complement otherwise.
    logic [15:0] mem_arr [256];
    logic [15:0] ref_mem [256];
    int en_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_cnt <= 0;
        else        en_cnt <= mem_en ? en_cnt + 1 : 0;
    end
    assign mem_rdata  = (mem_en && en_cnt == LAT - 1) ? mem_arr[mem_addr[7:0]] : ~mem_arr[mem_addr[7:0]];
    assign mem_rdata1 = mem_en1 ? 16'h3C3C : 16'h0000;

    int checks, errors, cyc;
    int m_side;              // 0 none, 1 fetch, 2 data
    int m_g;                 // cycle whose closing edge granted the transaction
    logic m_last;            // 1 = data won the last tie
    logic m_we;
    logic [15:0] m_addr, m_wdata, m_data, exp_ir, exp_dr;
    bit pend_i, pend_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy(input int c);
        return (m_side != 0) && (c >= m_g + 1) && (c <= m_g + LAT);
    endfunction

    function automatic bit m_rdy(input int c);
        return (m_side != 0) && (c == m_g + LAT + 1);
    endfunction

    task automatic model_reset();
        m_side = 0;
        m_last = 1'b0;
        exp_ir = '0;
        exp_dr = '0;
    endtask

    task automatic model_grant();
        if (!rst_n) return;
        if (m_side != 0 && cyc <= m_g + LAT + 1) return;
        m_side = 0;
        if (i_req && d_req) begin
            m_side = m_last ? 1 : 2;
            m_last = (m_side == 2);
        end else if (d_req) m_side = 2;
        else if (i_req) m_side = 1;
        if (m_side != 0) begin
            m_g = cyc;
            if (m_side == 2) begin
                m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
            end else begin
                m_addr = i_addr; m_we = 1'b0; m_wdata = '0;
            end
            m_data = ref_mem[m_addr[7:0]];
            if (m_side == 2 && m_we) ref_mem[m_addr[7:0]] = m_wdata;
        end
    endtask

    task automatic check_cycle();
        bit busy, rdy;
        busy = m_busy(cyc);
        rdy  = m_rdy(cyc);
        if (rdy && m_side == 1) exp_ir = m_data;
        if (rdy && m_side == 2 && !m_we) exp_dr = m_data;
        chk("mem_en", mem_en, busy);
        chk("mem_we", mem_we, busy && m_side == 2 && m_we);
        if (busy) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, (m_side == 2) ? m_wdata : 16'h0);
        end
        chk("i_ready", i_ready, rdy && m_side == 1);
        chk("d_ready", d_ready, rdy && m_side == 2);
        chk("i_rdata", i_rdata, exp_ir);
        chk("d_rdata", d_rdata, exp_dr);
        chk("i_stall", i_stall, i_req && !(rdy && m_side == 1));
        chk("d_stall", d_stall, d_req && !(rdy && m_side == 2));
        if (mem_en && mem_we && en_cnt == LAT - 1) mem_arr[mem_addr[7:0]] = mem_wdata;
    endtask

    task automatic cycle();
        model_grant();
        @(negedge clk);
        cyc++;
        check_cycle();
    endtask

    task automatic run(input int n, input bit hold);
        repeat (n) begin
            cycle();
            if (!hold && m_rdy(cyc) && m_side == 1) i_req = 1'b0;
            if (!hold && m_rdy(cyc) && m_side == 2) d_req = 1'b0;
        end
    endtask

    task automatic chk_reset();
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_mem_wdata", mem_wdata, 16'h0);
        chk("rst_i_ready", i_ready, 1'b0);
        chk("rst_d_ready", d_ready, 1'b0);
        chk("rst_i_rdata", i_rdata, 16'h0);
        chk("rst_d_rdata", d_rdata, 16'h0);
        chk("rst_i_stall", i_stall, i_req);
        chk("rst_d_stall", d_stall, d_req);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; m_g = 0;
        pend_i = 0; pend_d = 0;
        for (int k = 0; k < 256; k++) begin
            mem_arr[k] = 16'($urandom);
            ref_mem[k] = mem_arr[k];
        end
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        i_req1 = 0; i_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0;
        model_reset();

        // reset values, stall follows request while in reset
        repeat (2) @(negedge clk);
        i_req = 1'b1;
        #1;
        chk_reset();
        i_req = 1'b0;
        rst_n = 1'b1;

        // single fetch
        mem_arr[8'h10] = 16'hA5A5; ref_mem[8'h10] = 16'hA5A5;
        i_addr = 16'h0010; i_req = 1'b1;
        run(8, 0);
        chk("fetch_rdata", i_rdata, 16'hA5A5);

        // data write leaves d_rdata untouched
        d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234; d_req = 1'b1;
        run(8, 0);
        chk("write_mem", mem_arr[8'h00], 16'h1234);
        chk("write_drdata", d_rdata, 16'h0000);

        // simultaneous requests held from reset: D, I, D, I
        rst_n = 1'b0;
        #1;
        chk_reset();
        model_reset();
        rst_n = 1'b1;
        d_we = 1'b0; d_addr = 16'h0040; i_addr = 16'h0030;
        i_req = 1'b1; d_req = 1'b1;
        for (int t = 1; t <= 23; t++) begin
            cycle();
            if (t == 5)  chk("tie_d_first", d_ready, 1'b1);
            if (t == 11) chk("tie_i_second", i_ready, 1'b1);
            if (t == 17) chk("tie_d_third", d_ready, 1'b1);
            if (t == 23) chk("tie_i_fourth", i_ready, 1'b1);
        end
        i_req = 1'b0; d_req = 1'b0;
        run(3, 0);

        // fetch request dropped mid-busy still completes
        i_addr = 16'h0055; i_req = 1'b1;
        run(2, 0);
        i_req = 1'b0;
        run(3, 0);
        chk("drop_i_ready", i_ready, 1'b1);
        chk("drop_i_rdata", i_rdata, ref_mem[8'h55]);
        run(2, 0);

        // reset in the third busy cycle of a data read
        d_we = 1'b0; d_addr = 16'h0077; d_req = 1'b1;
        run(3, 0);
        d_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset();
        model_reset();
        rst_n = 1'b1;
        run(8, 0);
        d_req = 1'b1;
        run(8, 0);
        chk("after_rst_drdata", d_rdata, ref_mem[8'h77]);

        // single-cycle latency instance
        i_addr1 = 16'h0099; i_req1 = 1'b1;
        cycle();
        chk("lat1_en_c1", mem_en1, 1'b1);
        chk("lat1_addr_c1", mem_addr1, 16'h0099);
        chk("lat1_rdy_c1", i_ready1, 1'b0);
        cycle();
        chk("lat1_en_c2", mem_en1, 1'b0);
        chk("lat1_rdy_c2", i_ready1, 1'b1);
        chk("lat1_rdata", i_rdata1, 16'h3C3C);
        i_req1 = 1'b0;
        cycle();
        chk("lat1_rdy_c3", i_ready1, 1'b0);

        // random requesters
        for (int n = 0; n < 3000; n++) begin
            if (m_rdy(cyc) && m_side == 1) begin
                pend_i = 0;
                if ($urandom_range(3) != 0) i_req = 1'b0;
                else begin pend_i = 1; i_addr = 16'($urandom); end
            end else if (!pend_i && !i_req && $urandom_range(2) == 0) begin
                i_req = 1'b1; pend_i = 1; i_addr = 16'($urandom);
            end else if (m_busy(cyc) && m_side == 1) begin
                i_addr = 16'($urandom);
                if (i_req && $urandom_range(15) == 0) i_req = 1'b0;
            end
            if (m_rdy(cyc) && m_side == 2) begin
                pend_d = 0;
                if ($urandom_range(3) != 0) d_req = 1'b0;
                else begin
                    pend_d = 1; d_addr = 16'($urandom); d_we = 1'($urandom); d_wdata = 16'($urandom);
                end
            end else if (!pend_d && !d_req && $urandom_range(2) == 0) begin
                d_req = 1'b1; pend_d = 1;
                d_addr = 16'($urandom); d_we = 1'($urandom); d_wdata = 16'($urandom);
            end else if (m_busy(cyc) && m_side == 2) begin
                d_addr = 16'($urandom); d_we = 1'($urandom); d_wdata = 16'($urandom);
                if (d_req && $urandom_range(15) == 0) d_req = 1'b0;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
